uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 10 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/uart_rx_fifo.sv | 95 +++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, parity modes and output field positions
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD = 1;
   localparam int PAR_EVEN = 2;
   localparam int OUT_EMPTY = 15;
   localparam int OUT_FERR = 14;
   localparam int OUT_PERR = 13;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO with registered head word and empty flag
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [PW:0] cnt, cnt_n;
   logic [WIDTH-1:0] head_n;
   logic do_push, do_pop;
   assign full = cnt == (PW+1)'(DEPTH);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // next occupancy and next head word, so head/empty come straight from flops
   always_comb begin
      cnt_n = cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
      head_n = do_pop ? (cnt == (PW+1)'(1) ? (do_push ? din : '0) : mem[rptr + PW'(1)])
             : (do_push && empty) ? din : head;
   end
   // pointers, occupancy and the presented head
   always_ff @(posedge clk or posedge clear)
      if (clear) begin
         wptr <= '0;
         rptr <= '0;
         cnt <= '0;
         empty <= 1'b1;
         head <= '0;
      end else begin
         if (do_push) wptr <= wptr + PW'(1);
         if (do_pop) rptr <= rptr + PW'(1);
         cnt <= cnt_n;
         empty <= (cnt_n == '0);
         head <= head_n;
      end
   // storage array, deliberately left out of reset
   always_ff @(posedge clk)
      if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with mid-bit sampling feeding a small word FIFO
module uart_rx_fifo import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS = 8,
   parameter int PARITY = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        RX,
   input  logic        rd,
   output logic [15:0] out,
   output logic        overrun
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
   state_t state;
   logic rx_meta, rxs, perr, push, full, empty, baud_end;
   logic [BW-1:0] baud;
   logic [2:0] bitc;
   logic [DATA_BITS-1:0] sh;
   logic [9:0] head;
   assign baud_end = baud == BAUD_LAST;
   assign push = state == STOP && baud_end;
   // two-flop synchroniser, preset high so clear never fakes a start bit
   always_ff @(posedge clk or posedge clear)
      if (clear) {rx_meta, rxs} <= 2'b11;
      else {rx_meta, rxs} <= {RX, rx_meta};
   // frame FSM: start bit checked at its centre, later bits one full bit apart
   always_ff @(posedge clk or posedge clear)
      if (clear) begin
         state <= IDLE;
         baud <= '0;
         bitc <= '0;
         sh <= '0;
         perr <= 1'b0;
      end else
         case (state)
            IDLE: begin
               baud <= '0;
               bitc <= '0;
               perr <= 1'b0;
               if (!rxs) state <= START;
            end
            START:
               if (baud == HALF_LAST) begin
                  baud <= '0;
                  state <= rxs ? IDLE : DATA;
               end else baud <= baud + BW'(1);
            DATA: begin
               baud <= baud_end ? '0 : baud + BW'(1);
               if (baud_end) begin
                  sh <= {rxs, sh[DATA_BITS-1:1]};
                  bitc <= bitc + 3'd1;
                  if (bitc == BIT_LAST) state <= PARITY != PAR_NONE ? PAR : STOP;
               end
            end
            PAR: begin
               baud <= baud_end ? '0 : baud + BW'(1);
               if (baud_end) begin
                  perr <= (^sh ^ rxs) != (PARITY == PAR_ODD);
                  state <= STOP;
               end
            end
            STOP: begin
               baud <= baud_end ? '0 : baud + BW'(1);
               if (baud_end) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
   sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .clear (clear),
      .push  (push),
      .pop   (rd),
      .din   ({~rxs, perr, 8'(sh)}),
      .full  (full),
      .empty (empty),
      .head  (head)
   );
   // output word assembled from the FIFO's registered head and empty flag
   always_comb begin
      out = {8'b0, head[7:0]};
      out[OUT_EMPTY] = empty;
      out[OUT_FERR] = head[9];
      out[OUT_PERR] = head[8];
   end
   // sticky drop flag: a new drop outranks a clearing read
   always_ff @(posedge clk or posedge clear)
      if (clear) overrun <= 1'b0;
      else if (push && full && !rd) overrun <= 1'b1;
      else if (rd && !empty) overrun <= 1'b0;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
   logic clk, clear, rx_d, rx_p, rd_d, rd_p, rd_mon, rd_man, ovr_d, ovr_p, mon_en;
   logic [15:0] out_d, out_p;
   logic [15:0] exp_q[$];
   int cyc = 0, t0 = 0, n_cmp = 0, n_bad = 0;

   assign rd_p = rd_mon | rd_man;

   uart_rx_fifo dut_d (.clk(clk), .clear(clear), .RX(rx_d), .rd(rd_d), .out(out_d), .overrun(ovr_d));
   uart_rx_fifo #(.CLKS_PER_BIT(16), .PARITY(2)) dut_p (
      .clk(clk), .clear(clear), .RX(rx_p), .rd(rd_p), .out(out_p), .overrun(ovr_p));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic set_rx(input bit p, input logic v);
      if (p) rx_p = v;
      else rx_d = v;
   endtask

   // serial frame: start, data LSB first, optional even parity, stop, idle gap
   task automatic send(input bit p, input logic [7:0] d, input bit pflip, input bit sbad);
      int cpb;
      cpb = p ? 16 : 217;
      @(negedge clk);
      t0 = cyc;
      set_rx(p, 1'b0);
      repeat (cpb) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_rx(p, d[i]);
         repeat (cpb) @(negedge clk);
      end
      if (p) begin
         set_rx(p, (^d) ^ pflip);
         repeat (cpb) @(negedge clk);
      end
      set_rx(p, !sbad);
      repeat (cpb) @(negedge clk);
      set_rx(p, 1'b1);
      repeat (2 * cpb + $urandom_range(0, cpb)) @(negedge clk);
   endtask

   task automatic watch(input bit p, output int seen);
      seen = -1;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (!(p ? out_p[15] : out_d[15])) begin
            seen = cyc;
            break;
         end
      end
   endtask

   // frame whose word must appear one cycle after the stop-bit sample
   task automatic send_chk(input bit p, input logic [7:0] d, input bit pflip, input bit sbad,
                           input logic [15:0] exp);
      int seen, lat;
      lat = p ? 3 + 8 + 16 * 10 : 3 + 108 + 217 * 9;
      fork
         send(p, d, pflip, sbad);
         watch(p, seen);
      join
      check($sformatf("latency_%0h", d), seen - t0, lat);
      check($sformatf("word_%0h", d), p ? out_p : out_d, exp);
   endtask

   task automatic pulse_rd_d();
      @(negedge clk);
      rd_d = 1'b1;
      @(negedge clk);
      rd_d = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 3000 && exp_q.size() > 0; k++) @(negedge clk);
      check("sb_drain_left", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // scoreboard monitor: compares each presented head, then pops it
   initial begin
      logic [15:0] e;
      rd_mon = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && !out_p[15] && $urandom_range(0, 2) != 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL sb_unexpected: got 0x%0h expected no word", out_p);
            end else begin
               e = exp_q.pop_front();
               if (out_p !== e) begin
                  n_bad++;
                  $display("FAIL sb_word: got 0x%0h expected 0x%0h", out_p, e);
               end
            end
            rd_mon = 1'b1;
         end else rd_mon = 1'b0;
      end
   end

   initial begin
      logic [7:0] d;
      bit pf, sb;
      clear = 1'b1;
      rx_d = 1'b1;
      rx_p = 1'b1;
      rd_d = 1'b0;
      rd_man = 1'b0;
      mon_en = 1'b0;
      #1;
      check("reset_out", out_d, 16'h8000);
      check("reset_ovr", ovr_d, 0);
      repeat (3) @(negedge clk);
      clear = 1'b0;
      repeat (5) @(negedge clk);
      send_chk(0, 8'h55, 0, 0, 16'h0055);
      pulse_rd_d();
      check("rd_55_empty", out_d, 16'h8000);
      send_chk(0, 8'h0F, 0, 1, 16'h400F);
      pulse_rd_d();
      send_chk(0, 8'h5A, 0, 0, 16'h005A);
      pulse_rd_d();
      for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 0);
      check("ovr_set", ovr_d, 1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovr_head_%0d", i), out_d, i);
         pulse_rd_d();
         check($sformatf("ovr_clr_%0d", i), ovr_d, 0);
      end
      check("ovr_all_read", out_d, 16'h8000);
      pulse_rd_d();
      check("rd_while_empty", out_d, 16'h8000);
      @(negedge clk);
      rx_d = 1'b0;
      repeat (50) @(negedge clk);
      rx_d = 1'b1;
      repeat (400) @(negedge clk);
      check("glitch_no_push", out_d, 16'h8000);
      send_chk(0, 8'h96, 0, 0, 16'h0096);
      pulse_rd_d();
      send_chk(0, 8'h3C, 0, 0, 16'h003C);
      d = 8'hC3;
      @(negedge clk);
      rx_d = 1'b0;
      repeat (217) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx_d = d[i];
         repeat (217) @(negedge clk);
      end
      rx_d = d[3];
      repeat (100) @(negedge clk);
      #2 clear = 1'b1;
      #1;
      check("clear_out_now", out_d, 16'h8000);
      check("clear_ovr_now", ovr_d, 0);
      rx_d = 1'b1;
      repeat (3) @(negedge clk);
      clear = 1'b0;
      repeat (434) @(negedge clk);
      check("after_clear_idle", out_d, 16'h8000);
      send_chk(0, 8'hC3, 0, 0, 16'h00C3);
      pulse_rd_d();
      mon_en = 1'b1;
      exp_q.push_back(16'h00A3);
      send(1, 8'hA3, 0, 0);
      exp_q.push_back(16'h20A3);
      send(1, 8'hA3, 1, 0);
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         pf = $urandom_range(0, 3) == 0;
         sb = $urandom_range(0, 5) == 0;
         exp_q.push_back({1'b0, sb, pf, 5'b0, d});
         send(1, d, pf, sb);
      end
      drain();
      mon_en = 1'b0;
      repeat (3) @(negedge clk);
      send(1, 8'h11, 0, 0);
      send(1, 8'h22, 0, 0);
      send(1, 8'h33, 0, 0);
      send(1, 8'h44, 0, 0);
      check("full_head", out_p, 16'h0011);
      fork
         send(1, 8'h55, 0, 0);
         begin
            @(negedge clk);
            repeat (170) @(negedge clk);
            rd_man = 1'b1;
            @(negedge clk);
            rd_man = 1'b0;
         end
      join
      check("full_pop_ovr", ovr_p, 0);
      check("full_pop_head", out_p, 16'h0022);
      exp_q.push_back(16'h0022);
      exp_q.push_back(16'h0033);
      exp_q.push_back(16'h0044);
      exp_q.push_back(16'h0055);
      mon_en = 1'b1;
      drain();
      mon_en = 1'b0;
      check("final_empty", out_p, 16'h8000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
